seven_seg_scan_ctrl: RTL and testbench
======================================

// Module: seven_seg_scan_ctrl
//
// PURPOSE
// Time-multiplexes one shared bin_to_7_seg decoder across a 4-digit common-anode display.
// Latches a 16-bit value (4 nibbles), then cycles through the digits one slot at a time.
// In each slot it drives the digit's nibble to the decoder and asserts that digit's anode.
// It inserts a dead-time blank between digits to stop ghosting, and updates the displayed
// value only at frame boundaries, so a frame never shows a mix of old and new digits.
//
// PARAMETERS
// SCAN_DIV     50000  clock cycles per digit slot; legal range >= 2
// DEAD_CYCLES  16     blank cycles at the start of each slot; must be < SCAN_DIV
//
// PORTS
// clk         in   1   system clock; every register updates on its rising edge
// reset       in   1   synchronous, active-high reset
// load        in   1   one-cycle strobe: capture value into the shadow register
// value       in   16  nibble k drives digit k; digit 0 is rightmost
// digit_en    in   4   per-digit enable; a disabled digit's anode stays off for its slot
// bin_out     out  4   nibble for the active digit; connects to the decoder's bin_input
// an          out  4   anode selects, active-low; one-hot-low or 4'b1111
// blank       out  1   1 = decoder segments must be off
// frame_sync  out  1   one-cycle pulse on the wrap from digit 3 to digit 0
//
// BEHAVIOUR
// - Registers: slot counter cnt (0..SCAN_DIV-1), digit index idx (0..3),
//   shadow register shd[15:0], display register disp[15:0].
// - All outputs are registered. There is no combinational path from any input to any output.
// - Reset values: cnt=0, idx=0, shd=0, disp=0, bin_out=0, an=4'b1111, blank=1, frame_sync=0.
// - Reset applied mid-scan takes effect at the next edge, whatever the current state.
// - Counting: cnt increments every cycle.
// - At cnt==SCAN_DIV-1, cnt wraps to 0 and idx advances: 0->1->2->3->0.
// - Two-state FSM per slot:
//   - DEAD, while cnt < DEAD_CYCLES: an=4'b1111, blank=1.
//   - SHOW, while cnt >= DEAD_CYCLES: an[idx]=0 and blank=0 if digit_en[idx]=1;
//     otherwise an=4'b1111 and blank=1.
// - Output timing: outputs reflect the cnt/idx state of the previous cycle (1-cycle latency).
// - bin_out = disp[4*idx+3 -: 4] in every state; it is don't-care while blank=1 but must be stable.
// - Load: when load=1, shd <= value on that edge. disp is not changed by the load.
// - Frame boundary: the edge where idx wraps 3->0 does disp <= shd.
//   - The same edge sets frame_sync=1 for exactly one cycle.
// - Load on the frame-boundary edge: the incoming value bypasses shd into disp
//   (disp <= value, shd <= value).
// - Repeated loads within one frame: last write wins. Only the final shd reaches disp.
// - digit_en is sampled every cycle, so a change takes effect mid-slot at the next edge.
// - Digit slots are always consumed, whether enabled or not; frame period = 4*SCAN_DIV cycles.
//
// CONFIGURATION
// - Macro LZ_BLANK_EN (optional feature: leading-zero suppression).
//   - Defined: digit k (k=3..1) is treated as disabled when disp[15:4k] == 0.
//     Digit 0 is never suppressed; digit_en still applies to it.
//     Example: disp=16'h0042 lights digits 1 and 0 only.
//   - Not defined: every enabled digit is shown, including leading zeros.
//     No extra comparator logic is built.
//
// TESTING  (SCAN_DIV=8, DEAD_CYCLES=2 unless noted)
// 1. Hold reset 3 cycles, then release.
//    -> While reset is high: an=1111, blank=1, bin_out=0, frame_sync=0.
//    -> After release: first SHOW on digit 0 appears 3 cycles later.
// 2. load=1 with value=16'h1234, then free-run 2 frames.
//    -> Frame 1 shows 0000. Frame 2 shows digits 0..3 = 4,3,2,1, with an=1110,1101,1011,0111.
//    -> Each SHOW lasts 6 cycles after a 2-cycle blank. frame_sync pulses every 32 cycles.
// 3. digit_en=4'b0101 with disp=16'hABCD.
//    -> Only an=1110 (D) and an=1011 (B) are ever asserted.
//    -> Slots 1 and 3 stay at an=1111, blank=1 for all 8 cycles.
// 4. load asserted on the frame-boundary edge with value=16'h5A5A.
//    -> The immediately following frame shows A,5,A,5 (bypass).
//    -> A load of 16'h0001 mid-frame appears only from the next frame.
// 5. Assert reset while digit 2 is in SHOW.
//    -> Next cycle: an=1111, idx=0, disp=0. No partial slot completes.
// 6. LZ_BLANK_EN defined, disp=16'h0007.
//    -> Only digit 0 ever lights. disp=16'h0000 -> digit 0 lights showing 0.
//    -> Without the macro, all four digits light.

Source files
------------

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed 4-digit common-anode scan controller sharing one 7-seg decoder.
// Optional leading-zero suppression is built when LZ_BLANK_EN is defined.
module seven_seg_scan_ctrl #(
  parameter int SCAN_DIV    = 50000,
  parameter int DEAD_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  digit_en,
  output logic [3:0]  bin_out,
  output logic [3:0]  an,
  output logic        blank,
  output logic        frame_sync
);

  localparam int CW = $clog2(SCAN_DIV);

  typedef enum logic {DEAD, SHOW} state_e;

  // A zero-length dead time means every slot opens directly in SHOW.
  localparam state_e SLOT_START = (DEAD_CYCLES == 0) ? SHOW : DEAD;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   shd_q, shd_d;
  logic [15:0]   disp_q, disp_d;
  state_e        state_q, state_d;

  logic [3:0]    bin_q, bin_d;
  logic [3:0]    an_q, an_d;
  logic          blank_q, blank_d;
  logic          fsync_q, fsync_d;

  logic          slot_last;
  logic          frame_wrap;
  logic [3:0]    en_eff;

  assign slot_last  = (cnt_q == CW'(SCAN_DIV - 1));
  assign frame_wrap = slot_last && (idx_q == 2'd3);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SLOT_START;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (slot_last) begin
      state_d = SLOT_START;
    end else if (DEAD_CYCLES > 0 && cnt_q == CW'(DEAD_CYCLES - 1)) begin
      state_d = SHOW;
    end
  end

  // Loading on the frame edge passes the new value straight into disp.
  always_comb begin
    cnt_d  = slot_last ? '0 : cnt_q + 1'b1;
    idx_d  = slot_last ? idx_q + 2'd1 : idx_q;
    shd_d  = load ? value : shd_q;
    disp_d = frame_wrap ? shd_d : disp_q;
  end

`ifdef LZ_BLANK_EN
  always_comb begin
    en_eff = digit_en & {|disp_q[15:12], |disp_q[15:8], |disp_q[15:4], 1'b1};
  end
`else
  always_comb begin
    en_eff = digit_en;
  end
`endif

  always_comb begin
    bin_d   = disp_q[{idx_q, 2'b00} +: 4];
    an_d    = 4'b1111;
    blank_d = 1'b1;
    fsync_d = frame_wrap;
    if (state_q == SHOW && en_eff[idx_q]) begin
      an_d[idx_q] = 1'b0;
      blank_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      shd_q   <= 16'h0000;
      disp_q  <= 16'h0000;
      bin_q   <= 4'h0;
      an_q    <= 4'b1111;
      blank_q <= 1'b1;
      fsync_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shd_q   <= shd_d;
      disp_q  <= disp_d;
      bin_q   <= bin_d;
      an_q    <= an_d;
      blank_q <= blank_d;
      fsync_q <= fsync_d;
    end
  end

  assign bin_out    = bin_q;
  assign an         = an_q;
  assign blank      = blank_q;
  assign frame_sync = fsync_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Scoreboard bench for seven_seg_scan_ctrl (SCAN_DIV=8, DEAD_CYCLES=2).
module tb_seven_seg_scan_ctrl;

  localparam int SD = 8;
  localparam int DC = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = 16'h0000;
  logic [3:0]  digit_en = 4'hF;
  logic [3:0]  bin_out;
  logic [3:0]  an;
  logic        blank;
  logic        frame_sync;

  seven_seg_scan_ctrl #(.SCAN_DIV(SD), .DEAD_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .load(load), .value(value), .digit_en(digit_en),
    .bin_out(bin_out), .an(an), .blank(blank), .frame_sync(frame_sync)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] bin;
    logic [3:0] an;
    logic       blank;
    logic       fs;
  } exp_t;

  exp_t sbq[$];

  int n_chk = 0;
  int n_err = 0;

  // reference model state
  int          m_cnt = 0;
  int          m_idx = 0;
  logic [15:0] m_shd = 16'h0000;
  logic [15:0] m_disp = 16'h0000;

  // observation tallies
  logic [3:0] lit_mask;
  int         bad_an, d0_cnt, d2_cnt, fs_cnt;

  task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    exp_t       e;
    logic [3:0] oh;
    logic       en;
    logic       show;
    if (reset) begin
      e = '{bin: 4'h0, an: 4'hF, blank: 1'b1, fs: 1'b0};
      m_cnt = 0; m_idx = 0; m_shd = 16'h0000; m_disp = 16'h0000;
    end else begin
      show = (m_cnt >= DC);
      en   = digit_en[m_idx];
`ifdef LZ_BLANK_EN
      if (m_idx != 0 && (m_disp >> (4 * m_idx)) == 16'h0000) en = 1'b0;
`endif
      oh      = 4'b0001 << m_idx;
      e.bin   = 4'((m_disp >> (4 * m_idx)) & 16'h000F);
      e.an    = (show && en) ? ~oh : 4'hF;
      e.blank = !(show && en);
      e.fs    = (m_cnt == SD - 1) && (m_idx == 3);
      if (load) m_shd = value;
      if (e.fs) m_disp = m_shd;
      if (m_cnt == SD - 1) begin
        m_cnt = 0;
        m_idx = (m_idx + 1) % 4;
      end else begin
        m_cnt++;
      end
    end
    sbq.push_back(e);
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      chk("sb_empty", 16'd1, 16'd0);
    end else begin
      e = sbq.pop_front();
      chk("bin_out", 16'(bin_out), 16'(e.bin));
      chk("an", 16'(an), 16'(e.an));
      chk("blank", 16'(blank), 16'(e.blank));
      chk("frame_sync", 16'(frame_sync), 16'(e.fs));
    end
    lit_mask = lit_mask | ~an;
    if (an != 4'hF && an != 4'hE && an != 4'hB) bad_an++;
    if (an == 4'hE) d0_cnt++;
    if (an == 4'hB) d2_cnt++;
    if (frame_sync) fs_cnt++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Stops with the next tick being the frame-boundary edge.
  task automatic run_to_boundary();
    for (int i = 0; i < 100; i++) begin
      if (m_cnt == SD - 1 && m_idx == 3) return;
      tick();
    end
    chk("boundary_timeout", 16'd1, 16'd0);
  endtask

  task automatic do_load(input logic [15:0] v);
    load = 1'b1; value = v;
    tick();
    load = 1'b0;
  endtask

  initial begin
    int n;
    logic [3:0] exp_lz7;
    lit_mask = 4'h0; bad_an = 0; d0_cnt = 0; d2_cnt = 0; fs_cnt = 0;

    // 1: reset and first-show latency
    ticks(3);
    chk("rst_an", 16'(an), 16'hF);
    chk("rst_bin", 16'(bin_out), 16'h0);
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick(); n++;
      if (an != 4'hF) break;
    end
    chk("t1_first_show", 16'(n), 16'd3);

    // 2: load 1234, frame 2 shows it, frame_sync period
    do_load(16'h1234);
    run_to_boundary();
    tick();
    ticks(3);
    chk("t2_d0_bin", 16'(bin_out), 16'h4);
    chk("t2_d0_an", 16'(an), 16'hE);
    fs_cnt = 0;
    ticks(64);
    chk("t2_fs_count", 16'(fs_cnt), 16'd2);

    // 3: digit_en=0101 with ABCD
    digit_en = 4'b0101;
    do_load(16'hABCD);
    run_to_boundary();
    tick();
    bad_an = 0; d0_cnt = 0; d2_cnt = 0;
    ticks(32);
    chk("t3_bad_an", 16'(bad_an), 16'd0);
    chk("t3_d0_cycles", 16'(d0_cnt), 16'd6);
    chk("t3_d2_cycles", 16'(d2_cnt), 16'd6);
    digit_en = 4'hF;

    // 4: load on the boundary edge bypasses, mid-frame load waits
    run_to_boundary();
    do_load(16'h5A5A);
    ticks(3);
    chk("t4_bypass_bin", 16'(bin_out), 16'hA);
    chk("t4_bypass_an", 16'(an), 16'hE);
    ticks(5);
    do_load(16'h0001);
    ticks(6);
    chk("t4_old_frame_d1", 16'(bin_out), 16'h5);
    run_to_boundary();
    tick();
    ticks(3);
    chk("t4_next_frame_bin", 16'(bin_out), 16'h1);

    // 5: reset while digit 2 is in SHOW
    for (int i = 0; i < 100; i++) begin
      if (m_idx == 2 && m_cnt == 4) break;
      tick();
    end
    chk("t5_reached_d2", 16'(an), 16'hB);
    reset = 1'b1;
    tick();
    chk("t5_rst_an", 16'(an), 16'hF);
    chk("t5_rst_bin", 16'(bin_out), 16'h0);
    reset = 1'b0;
    ticks(3);
    chk("t5_restart_an", 16'(an), 16'hE);

    // 6: leading-zero behaviour
`ifdef LZ_BLANK_EN
    exp_lz7 = 4'b0001;
`else
    exp_lz7 = 4'b1111;
`endif
    do_load(16'h0007);
    run_to_boundary();
    tick();
    lit_mask = 4'h0;
    ticks(32);
    chk("t6_lit_0007", 16'(lit_mask), 16'(exp_lz7));
    do_load(16'h0000);
    run_to_boundary();
    tick();
    lit_mask = 4'h0;
    ticks(32);
    chk("t6_lit_0000", 16'(lit_mask), 16'(exp_lz7));

    // random loads and enable changes against the model
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) digit_en = 4'($urandom);
      load  = ($urandom_range(0, 9) == 0);
      value = 16'($urandom);
      tick();
    end
    load = 1'b0;
    ticks(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
